// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } mem_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Fields captured at grant time and consumed in the completion cycle.
    typedef struct packed {
        logic      is_load;
        logic [1:0] off;
        mem_size_t size;
        logic      u_load;
    } lsu_ctx_t;

    // The unused encoding 2'b11 behaves as a full word.
    function automatic mem_size_t decode_size(input logic [1:0] sel);
        mem_size_t s;
        case (sel)
            2'b00:   s = SIZE_B;
            2'b01:   s = SIZE_H;
            default: s = SIZE_W;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a read word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  mem_size_t   size,
    input  logic        u_load,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the lane by byte offset and extend to 32 bits
    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            SIZE_B:  data = {{24{~u_load & byte_sel[7]}}, byte_sel};
            SIZE_H:  data = {{16{~u_load & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: aligns stores, extends loads, runs req/gnt/rvalid handshake.
// Latency: request combinational in IDLE; load data valid in the rvalid cycle (min 2 cycles).
// Backpressure: StallM held while the bus has not granted or responded; no timeout.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [1:0]        s_selM,
    input  logic [1:0]        l_selM,
    input  logic              u_loadM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);

    lsu_state_t  state_q, state_d;
    lsu_ctx_t    ctx_q;
    mem_size_t   size;
    logic        is_store, is_load, access, misalign, issue;
    logic [1:0]  off;
    logic [3:0]  be_pat;
    logic [31:0] wdata_pat, load_data;

    // Decode access kind, size, alignment and the lane pattern from M-stage inputs
    always_comb begin
        is_store = MemWriteM;
        is_load  = (ResultSrcM == RESULT_SRC_LOAD) & ~MemWriteM;
        access   = is_store | is_load;
        size     = decode_size(is_store ? s_selM : l_selM);
        off      = ALUResultM[1:0];
        misalign = access & (((size == SIZE_H) & off[0]) |
                             ((size == SIZE_W) & (off != 2'b00)));
        issue    = access & ~misalign;
        case (size)
            SIZE_B: begin
                be_pat    = 4'b0001 << off;
                wdata_pat = {4{WriteDataM[7:0]}};
            end
            SIZE_H: begin
                be_pat    = 4'b0011 << off;
                wdata_pat = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_pat    = 4'b1111;
                wdata_pat = WriteDataM;
            end
        endcase
    end

    // State register; clr abandons any outstanding transaction
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture offset/size/extension at grant so the response is decoded consistently
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ctx_q <= '0;
        end else if (state_q == IDLE && state_d == WAIT) begin
            ctx_q.is_load <= is_load;
            ctx_q.off     <= off;
            ctx_q.size    <= size;
            ctx_q.u_load  <= u_loadM;
        end
    end

    // Next state: IDLE waits for a grant, WAIT waits for the single response
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue && dmem_gnt) state_d = WAIT;
            WAIT:    if (dmem_rvalid)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    lsu_load_align u_load_align (
        .rdata  (dmem_rdata),
        .off    (ctx_q.off),
        .size   (ctx_q.size),
        .u_load (ctx_q.u_load),
        .data   (load_data)
    );

    // Outputs; everything forced low while clr is asserted, rvalid in IDLE is ignored
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'h0;
        ReadDataM  = 32'h0;
        StallM     = 1'b0;
        MisalignM  = 1'b0;
        if (!clr) begin
            dmem_addr  = {ALUResultM[ADDR_W-1:2], 2'b00};
            dmem_we    = is_store;
            dmem_be    = be_pat;
            dmem_wdata = wdata_pat;
            case (state_q)
                IDLE: begin
                    dmem_req  = issue;
                    StallM    = issue;
                    MisalignM = misalign;
                end
                WAIT: begin
                    StallM = access & ~dmem_rvalid;
                    if (dmem_rvalid && ctx_q.is_load) ReadDataM = load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: drives pipeline + bus, checks requests and completions.
// Latency: bench models gnt/rvalid delays per access.
// Backpressure: bench holds M inputs stable while StallM is expected high.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        clr;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM, s_selM, l_selM;
    logic        u_loadM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk_wd;
    } req_exp_t;

    typedef struct {
        logic [31:0] rd;
        int          stall;
    } rsp_exp_t;

    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];
    int total = 0;
    int bad   = 0;
    int stall_cnt = 0;

    mem_stage_lsu dut (
        .clk         (clk),
        .clr         (clr),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .s_selM      (s_selM),
        .l_selM      (l_selM),
        .u_loadM     (u_loadM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .ReadDataM   (ReadDataM),
        .StallM      (StallM),
        .MisalignM   (MisalignM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        s_selM     = 2'b00;
        l_selM     = 2'b00;
        u_loadM    = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
    endtask

    // One access: gd cycles before gnt, rvalid rd cycles after gnt (rd >= 1).
    task automatic run_acc(input logic w, input logic [1:0] rsrc, input logic [1:0] ss,
                           input logic [1:0] ls, input logic u, input logic [31:0] a,
                           input logic [31:0] wd, input int gd, input int rd,
                           input logic [31:0] rdat, input logic stale,
                           input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
        req_exp_t rq;
        rsp_exp_t rs;
        rq.addr = {a[31:2], 2'b00};
        rq.we = w;
        rq.be = ebe;
        rq.wd = ewd;
        rq.chk_wd = w;
        req_q.push_back(rq);
        rs.rd = erd;
        rs.stall = gd + rd;
        rsp_q.push_back(rs);
        MemWriteM = w; ResultSrcM = rsrc; s_selM = ss; l_selM = ls; u_loadM = u;
        ALUResultM = a; WriteDataM = wd;
        for (int i = 0; i < gd; i++) begin
            dmem_rvalid = stale;
            dmem_rdata  = 32'hFFFF_FFFF;
            @(posedge clk); #1;
        end
        dmem_rvalid = 1'b0;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        for (int i = 0; i < rd; i++) begin
            if (i == rd - 1) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rdat;
            end
            @(negedge clk);
            check("req_in_wait", 32'(dmem_req), 32'h0);
            @(posedge clk); #1;
        end
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        set_idle();
    endtask

    // Request and completion scoreboard, sampled away from the active edge
    always @(negedge clk) begin
        if (clr) begin
            stall_cnt = 0;
        end else begin
            if (dmem_req && dmem_gnt) begin
                if (req_q.size() == 0) begin
                    check("req_extra", 32'h1, 32'h0);
                end else begin
                    req_exp_t r;
                    r = req_q.pop_front();
                    check("req_addr", dmem_addr, r.addr);
                    check("req_we", 32'(dmem_we), 32'(r.we));
                    check("req_be", 32'(dmem_be), 32'(r.be));
                    if (r.chk_wd) check("req_wdata", dmem_wdata, r.wd);
                end
            end
            if (MemWriteM || ResultSrcM == 2'b01) begin
                if (StallM) begin
                    stall_cnt++;
                end else if (!MisalignM) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_extra", 32'h1, 32'h0);
                    end else begin
                        rsp_exp_t e;
                        e = rsp_q.pop_front();
                        check("rdata", ReadDataM, e.rd);
                        check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        req_exp_t rq;
        clr = 1'b1;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h1234_5678;
        set_idle();
        MemWriteM = 1'b1; s_selM = 2'b10; ALUResultM = 32'h100; WriteDataM = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_we", 32'(dmem_we), 32'h0);
        check("rst_be", 32'(dmem_be), 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_stall", 32'(StallM), 32'h0);
        check("rst_mis", 32'(MisalignM), 32'h0);
        set_idle();
        dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;

        // w  rsrc   ss     ls     u     addr          wdata         gd rd rdata          st    be       exp_wd         exp_rd
        run_acc(1, 2'b00, 2'b10, 2'b00, 0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1, 32'h0,         0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        run_acc(1, 2'b00, 2'b00, 2'b00, 0, 32'h0000_0203, 32'h1234_56A5, 0, 1, 32'h0,         0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        run_acc(1, 2'b00, 2'b01, 2'b00, 0, 32'h0000_0102, 32'hCAFE_BEEF, 1, 2, 32'h0,         0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        run_acc(1, 2'b00, 2'b11, 2'b00, 0, 32'h0000_0104, 32'h0BAD_F00D, 0, 1, 32'h0,         0, 4'b1111, 32'h0BAD_F00D, 32'h0);
        run_acc(0, 2'b01, 2'b00, 2'b01, 0, 32'h0000_0202, 32'h0,         0, 1, 32'h8001_1234, 0, 4'b1100, 32'h0,         32'hFFFF_8001);
        run_acc(0, 2'b01, 2'b00, 2'b01, 1, 32'h0000_0202, 32'h0,         0, 1, 32'h8001_1234, 0, 4'b1100, 32'h0,         32'h0000_8001);
        run_acc(0, 2'b01, 2'b00, 2'b00, 0, 32'h0000_0101, 32'h0,         2, 3, 32'h0000_FF00, 0, 4'b0010, 32'h0,         32'hFFFF_FFFF);
        run_acc(0, 2'b01, 2'b00, 2'b00, 1, 32'h0000_0100, 32'h0,         0, 1, 32'h0000_FF80, 0, 4'b0001, 32'h0,         32'h0000_0080);
        run_acc(0, 2'b01, 2'b00, 2'b01, 0, 32'h0000_0200, 32'h0,         0, 2, 32'hABCD_7FFE, 0, 4'b0011, 32'h0,         32'h0000_7FFE);
        run_acc(0, 2'b01, 2'b00, 2'b10, 0, 32'h0000_0104, 32'h0,         0, 1, 32'h1234_5678, 0, 4'b1111, 32'h0,         32'h1234_5678);
        run_acc(0, 2'b01, 2'b00, 2'b11, 0, 32'h0000_0108, 32'h0,         1, 1, 32'h8765_4321, 0, 4'b1111, 32'h0,         32'h8765_4321);
        // load and store together behaves as a store
        run_acc(1, 2'b01, 2'b00, 2'b10, 0, 32'h0000_0301, 32'h0000_0077, 0, 1, 32'hFFFF_FFFF, 0, 4'b0010, 32'h7777_7777, 32'h0);

        // misaligned accesses: LW 0x102, LH 0x201, SW 0x101
        for (int k = 0; k < 3; k++) begin
            set_idle();
            case (k)
                0: begin ResultSrcM = 2'b01; l_selM = 2'b10; ALUResultM = 32'h102; end
                1: begin ResultSrcM = 2'b01; l_selM = 2'b01; ALUResultM = 32'h201; end
                default: begin MemWriteM = 1'b1; s_selM = 2'b10; ALUResultM = 32'h101; end
            endcase
            @(negedge clk);
            check("mis_pulse", 32'(MisalignM), 32'h1);
            check("mis_req", 32'(dmem_req), 32'h0);
            check("mis_stall", 32'(StallM), 32'h0);
            check("mis_rdata", ReadDataM, 32'h0);
            @(posedge clk); #1;
            set_idle();
            @(negedge clk);
            check("mis_clear", 32'(MisalignM), 32'h0);
            @(posedge clk); #1;
        end

        // clr while waiting for a response
        ResultSrcM = 2'b01; l_selM = 2'b10; ALUResultM = 32'h300;
        rq.addr = 32'h300; rq.we = 1'b0; rq.be = 4'b1111; rq.wd = 32'h0; rq.chk_wd = 1'b0;
        req_q.push_back(rq);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        check("wait_stall", 32'(StallM), 32'h1);
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        check("clr_req", 32'(dmem_req), 32'h0);
        check("clr_stall", 32'(StallM), 32'h0);
        check("clr_addr", dmem_addr, 32'h0);
        check("clr_be", 32'(dmem_be), 32'h0);
        set_idle();
        @(posedge clk); #1;
        clr = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_FF00;
        @(negedge clk);
        check("stale_rdata", ReadDataM, 32'h0);
        check("stale_stall", 32'(StallM), 32'h0);
        check("stale_req", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        // next access proceeds normally, with another stale rvalid before its grant
        run_acc(0, 2'b01, 2'b00, 2'b10, 0, 32'h0000_0300, 32'h0, 1, 1, 32'hC0DE_F00D, 1, 4'b1111, 32'h0, 32'hC0DE_F00D);

        @(posedge clk); #1;
        check("req_left", 32'(req_q.size()), 32'h0);
        check("rsp_left", 32'(rsp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
